// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants for the stopwatch prescaler and digit stages
package stopwatch_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // 1 kHz from the 250 MHz board clock
    localparam int unsigned PRESCALE_WIDTH = 18;
    localparam int unsigned PRESCALE_TC    = 249999;

    localparam int unsigned DIGIT_TC = 9;

endpackage

// File: rtl/prescale_counter.sv
// rtl/prescale_counter.sv - programmable up/down prescale counter with tick, carry and lap capture
module prescale_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH      = PRESCALE_WIDTH,
    parameter int unsigned DEFAULT_TC = PRESCALE_TC
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    input  logic             tc_load,
    input  logic [WIDTH-1:0] tc_in,
    input  logic             lap,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] tc,
    output logic             tick,
    output logic             carry,
    output logic [WIDTH-1:0] lap_count,
    output logic             lap_valid
);

    localparam logic [WIDTH-1:0] RESET_TC = WIDTH'(DEFAULT_TC);

    logic             wrap;
    logic [WIDTH-1:0] next_count;
    logic             next_tick;

    // >= rather than == so a terminal count lowered under the running count still wraps
    always_comb begin
        wrap = 1'b0;
        if (en && !clr) begin
            if (dir == DIR_DOWN) begin
                wrap = (count == '0);
            end else begin
                wrap = (count >= tc);
            end
        end
    end

    assign carry = wrap;

    always_comb begin
        next_count = count;
        next_tick  = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (!en) begin
            next_count = count;
        end else if (wrap) begin
            next_count = (dir == DIR_DOWN) ? tc : '0;
            next_tick  = 1'b1;
        end else if (dir == DIR_DOWN) begin
            next_count = count - 1'b1;
        end else begin
            next_count = count + 1'b1;
        end
    end

    // tc is written after next_count is formed, so a down-wrap on a load edge reloads the old tc
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            count     <= '0;
            tc        <= RESET_TC;
            tick      <= 1'b0;
            lap_count <= '0;
            lap_valid <= 1'b0;
        end else begin
            count     <= next_count;
            tick      <= next_tick;
            lap_valid <= lap;
            if (tc_load) begin
                tc <= tc_in;
            end
            if (lap) begin
                lap_count <= count;
            end
        end
    end

endmodule

// File: tb/tb_prescale_counter.sv
// tb/tb_prescale_counter.sv - randomized and directed checks of prescale_counter against a behavioural model
module tb_prescale_counter;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       dir = 1'b0;
    logic       tc_load = 1'b0;
    logic [3:0] tc_in = 4'd0;
    logic       lap = 1'b0;
    logic [3:0] count;
    logic [3:0] tc;
    logic       tick;
    logic       carry;
    logic [3:0] lap_count;
    logic       lap_valid;

    logic        b_rst_n = 1'b0;
    logic        b_en = 1'b0;
    logic        b_clr = 1'b0;
    logic        b_dir = 1'b0;
    logic        b_tc_load = 1'b0;
    logic [17:0] b_tc_in = 18'd0;
    logic        b_lap = 1'b0;
    logic [17:0] b_count;
    logic [17:0] b_tc;
    logic        b_tick;
    logic        b_carry;
    logic [17:0] b_lap_count;
    logic        b_lap_valid;

    int checks = 0;
    int errors = 0;

    // behavioural model of the WIDTH=4, DEFAULT_TC=9 instance
    logic [3:0] m_count = 4'd0;
    logic [3:0] m_tc = 4'd9;
    logic       m_tick = 1'b0;
    logic [3:0] m_lap = 4'd0;
    logic       m_lap_valid = 1'b0;

    always #5 CLK = ~CLK;

    prescale_counter #(.WIDTH(4), .DEFAULT_TC(9)) dut (
        .CLK(CLK), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
        .tc_load(tc_load), .tc_in(tc_in), .lap(lap),
        .count(count), .tc(tc), .tick(tick), .carry(carry),
        .lap_count(lap_count), .lap_valid(lap_valid)
    );

    prescale_counter dut_wide (
        .CLK(CLK), .rst_n(b_rst_n), .en(b_en), .clr(b_clr), .dir(b_dir),
        .tc_load(b_tc_load), .tc_in(b_tc_in), .lap(b_lap),
        .count(b_count), .tc(b_tc), .tick(b_tick), .carry(b_carry),
        .lap_count(b_lap_count), .lap_valid(b_lap_valid)
    );

    function automatic logic model_carry();
        int c;
        int t;
        c = m_count;
        t = m_tc;
        if (!en || clr) return 1'b0;
        if (dir) return (c == 0);
        return (c >= t);
    endfunction

    task automatic model_edge();
        int c;
        int t;
        logic w;
        c = m_count;
        t = m_tc;
        w = model_carry();
        if (!rst_n) begin
            m_count = 4'd0; m_tc = 4'd9; m_tick = 1'b0; m_lap = 4'd0; m_lap_valid = 1'b0;
            return;
        end
        m_lap_valid = lap;
        if (lap) m_lap = m_count;
        m_tick = 1'b0;
        if (clr) c = 0;
        else if (!en) c = c;
        else if (w) begin
            c = dir ? t : 0;
            m_tick = 1'b1;
        end else c = dir ? c - 1 : c + 1;
        m_count = 4'(c);
        if (tc_load) m_tc = tc_in;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic quiet_inputs();
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; dir = 1'b0;
        tc_load = 1'b0; tc_in = 4'd0; lap = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; dir = 1'b0; tc_load = 1'b1; tc_in = 4'd3; lap = 1'b1;
        step();
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (tc !== 4'd9) begin errors++; $display("FAIL reset_tc: got %0d expected 9", tc); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        checks++; if (lap_count !== 4'd0) begin errors++; $display("FAIL reset_lap_count: got %0d expected 0", lap_count); end
        checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL reset_lap_valid: got %b expected 0", lap_valid); end
        quiet_inputs();
    endtask

    task automatic test_count_up();
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 25; i++) begin
            #1;
            checks++; if (count !== 4'(i % 10)) begin errors++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, count, i % 10); end
            checks++; if (carry !== (i % 10 == 9)) begin errors++; $display("FAIL up_carry[%0d]: got %b expected %b", i, carry, i % 10 == 9); end
            checks++; if (tick !== (i > 0 && i % 10 == 0)) begin errors++; $display("FAIL up_tick[%0d]: got %b expected %b", i, tick, i > 0 && i % 10 == 0); end
            step();
        end
    endtask

    task automatic test_count_down();
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++; if (count !== 4'((10 - i % 10) % 10)) begin errors++; $display("FAIL down_count[%0d]: got %0d expected %0d", i, count, (10 - i % 10) % 10); end
            checks++; if (tick !== (i % 10 == 1)) begin errors++; $display("FAIL down_tick[%0d]: got %b expected %b", i, tick, i % 10 == 1); end
            checks++; if (carry !== (i % 10 == 0)) begin errors++; $display("FAIL down_carry[%0d]: got %b expected %b", i, carry, i % 10 == 0); end
            step();
        end
        // count is now 5
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (count !== 4'd5) begin errors++; $display("FAIL hold_count[%0d]: got %0d expected 5", i, count); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_tick[%0d]: got %b expected 0", i, tick); end
        end
        en = 1'b1;
        step();
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL resume_count: got %0d expected 4", count); end
        quiet_inputs();
    endtask

    task automatic test_tc_load();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (7) step();
        tc_load = 1'b1; tc_in = 4'd4;
        step();
        tc_load = 1'b0;
        #1;
        checks++; if (tc !== 4'd4) begin errors++; $display("FAIL load_tc: got %0d expected 4", tc); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL load_count: got %0d expected 8", count); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL load_carry_above_tc: got %b expected 1", carry); end
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL load_wrap_count: got %0d expected 0", count); end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL load_wrap_tick: got %b expected 1", tick); end
        tc_load = 1'b1; tc_in = 4'd0;
        step();
        tc_load = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL tc0_count[%0d]: got %0d expected 0", i, count); end
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tc0_tick[%0d]: got %b expected 1", i, tick); end
        end
        quiet_inputs();
    endtask

    task automatic test_clr();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (9) step();
        clr = 1'b1;
        #1;
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL clr_carry: got %b expected 0", carry); end
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", count); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL clr_tick: got %b expected 0", tick); end
        clr = 1'b0;
        repeat (3) step();
        clr = 1'b1; tc_load = 1'b1; tc_in = 4'd3;
        step();
        clr = 1'b0; tc_load = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_load_count: got %0d expected 0", count); end
        checks++; if (tc !== 4'd3) begin errors++; $display("FAIL clr_load_tc: got %0d expected 3", tc); end
        quiet_inputs();
    endtask

    task automatic test_lap_and_rearm();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (3) step();
        lap = 1'b1;
        step();
        checks++; if (lap_count !== 4'd3) begin errors++; $display("FAIL lap_first: got %0d expected 3", lap_count); end
        checks++; if (lap_valid !== 1'b1) begin errors++; $display("FAIL lap_valid_first: got %b expected 1", lap_valid); end
        step();
        lap = 1'b0;
        checks++; if (lap_count !== 4'd4) begin errors++; $display("FAIL lap_second: got %0d expected 4", lap_count); end
        checks++; if (lap_valid !== 1'b1) begin errors++; $display("FAIL lap_valid_second: got %b expected 1", lap_valid); end
        step();
        checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL lap_valid_drop: got %b expected 0", lap_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (count !== 4'd0 || tc !== 4'd9 || lap_count !== 4'd0 || lap_valid !== 1'b0 || tick !== 1'b0)
            begin errors++; $display("FAIL midrun_reset: got count=%0d tc=%0d lap=%0d lv=%b tick=%b expected 0 9 0 0 0", count, tc, lap_count, lap_valid, tick); end
        step();
        checks++; if (count !== 4'd1 || tick !== 1'b0) begin errors++; $display("FAIL restart: got count=%0d tick=%b expected 1 0", count, tick); end
        quiet_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(99) != 0);
            en      = ($urandom_range(9) != 0);
            clr     = ($urandom_range(29) == 0);
            dir     = ($urandom_range(49) == 0) ? ~dir : dir;
            tc_load = ($urandom_range(19) == 0);
            tc_in   = 4'($urandom_range(15));
            lap     = ($urandom_range(7) == 0);
            #1;
            checks++; if (carry !== model_carry()) begin errors++; $display("FAIL rnd_carry[%0d]: got %b expected %b", i, carry, model_carry()); end
            step();
            checks++; if (count !== m_count) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, m_count); end
            checks++; if (tc !== m_tc) begin errors++; $display("FAIL rnd_tc[%0d]: got %0d expected %0d", i, tc, m_tc); end
            checks++; if (tick !== m_tick) begin errors++; $display("FAIL rnd_tick[%0d]: got %b expected %b", i, tick, m_tick); end
            checks++; if (lap_count !== m_lap || lap_valid !== m_lap_valid)
                begin errors++; $display("FAIL rnd_lap[%0d]: got %0d/%b expected %0d/%b", i, lap_count, lap_valid, m_lap, m_lap_valid); end
        end
        quiet_inputs();
    endtask

    task automatic test_default_params();
        int ticks;
        ticks = 0;
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        checks++; if (b_tc !== 18'd249999) begin errors++; $display("FAIL wide_reset_tc: got %0d expected 249999", b_tc); end
        checks++; if (b_count !== 18'd0) begin errors++; $display("FAIL wide_reset_count: got %0d expected 0", b_count); end
        b_en = 1'b1; b_dir = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (b_tick) ticks++;
        end
        checks++; if (b_count !== 18'd1000) begin errors++; $display("FAIL wide_up_count: got %0d expected 1000", b_count); end
        b_dir = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (b_tick) ticks++;
        end
        checks++; if (ticks != 0) begin errors++; $display("FAIL wide_no_tick: got %0d expected 0", ticks); end
        #1;
        checks++; if (b_count !== 18'd0 || b_carry !== 1'b1) begin errors++; $display("FAIL wide_at_zero: got count=%0d carry=%b expected 0 1", b_count, b_carry); end
        step();
        checks++; if (b_count !== 18'd249999 || b_tick !== 1'b1) begin errors++; $display("FAIL wide_down_wrap: got count=%0d tick=%b expected 249999 1", b_count, b_tick); end
        b_en = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_count_up();
        test_count_down();
        test_tc_load();
        test_clr();
        test_lap_and_rearm();
        test_random();
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
